// File: rtl/cross_bus_receiver.sv
// cross_bus_receiver: destination-domain (clkB) capture side of the toggle-flag
// bus crossing. Each single-cycle flag pulse deposits BusIn into a small
// first-word-fall-through FIFO. The FIFO drains on a valid/ready stream.
// The crossing cannot be stalled, so a pulse that arrives while the FIFO is
// full (and nothing pops that cycle) is dropped. Drops are counted and flagged.
module cross_bus_receiver #(
    parameter int size       = 7,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clkB,
    input  logic                  rstB,
    input  logic                  FlagIn_clkB,
    input  logic [size:0]         BusIn,
    output logic [size:0]         DataOut,
    output logic                  Valid_clkB,
    input  logic                  Ready_clkB,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  Overflow_clkB,
    output logic [7:0]            DropCount,
    input  logic                  ClearOverflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Count value meaning "all slots occupied": only the top bit is set.
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [size:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;
    logic [7:0]            drop_cnt_q;

    logic full;
    logic valid;
    logic pop;
    logic push;
    logic drop;

    // Handshake decode. A pop frees a slot in the same cycle, so a full FIFO
    // can still accept a word whenever the consumer is taking one.
    always_comb begin
        full  = (count_q == FULL_CNT);
        valid = (count_q != '0);
        pop   = valid & Ready_clkB;
        push  = FlagIn_clkB & (~full | pop);
        drop  = FlagIn_clkB & full & ~pop;
    end

    // Storage array. It is not reset; its contents are unobservable while
    // the FIFO is empty because DataOut is masked.
    always_ff @(posedge clkB) begin
        if (push && !rstB)
            mem[wr_ptr] <= BusIn;
    end

    // Pointers and occupancy. Pointers wrap naturally at the depth.
    always_ff @(posedge clkB) begin
        if (rstB) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Overflow bookkeeping. A drop in the same cycle as a clear wins, so the
    // fresh drop is never lost: the flag stays set and the count restarts at 1.
    always_ff @(posedge clkB) begin
        if (rstB) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (ClearOverflow)
                drop_cnt_q <= 8'd1;
            else if (drop_cnt_q != 8'hFF)
                drop_cnt_q <= drop_cnt_q + 8'd1;
        end else if (ClearOverflow) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

    // Outputs depend on registers only; the head word is masked when empty.
    always_comb begin
        Valid_clkB    = valid;
        DataOut       = valid ? mem[rd_ptr] : '0;
        Count         = count_q;
        Overflow_clkB = overflow_q;
        DropCount     = drop_cnt_q;
    end

endmodule

// File: tb/tb_cross_bus_receiver.sv
// Bench for cross_bus_receiver: directed steps followed by a randomized phase.
// The outputs are compared each cycle against a queue-based reference model.
module tb_cross_bus_receiver;

    logic       clkB = 1'b0;
    logic       rstB = 1'b0;
    logic       FlagIn_clkB = 1'b0;
    logic [7:0] BusIn = '0;
    logic [7:0] DataOut;
    logic       Valid_clkB;
    logic       Ready_clkB = 1'b0;
    logic [2:0] Count;
    logic       Overflow_clkB;
    logic [7:0] DropCount;
    logic       ClearOverflow = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [7:0] q[$];
    bit         m_ovf = 0;
    int         m_drops = 0;

    cross_bus_receiver #(.size(7), .DEPTH_LOG2(2)) dut (
        .clkB          (clkB),
        .rstB          (rstB),
        .FlagIn_clkB   (FlagIn_clkB),
        .BusIn         (BusIn),
        .DataOut       (DataOut),
        .Valid_clkB    (Valid_clkB),
        .Ready_clkB    (Ready_clkB),
        .Count         (Count),
        .Overflow_clkB (Overflow_clkB),
        .DropCount     (DropCount),
        .ClearOverflow (ClearOverflow)
    );

    always #5 clkB = ~clkB;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the cycle's inputs to the model: a word is accepted if a slot is
    // free or the head leaves this cycle; otherwise it is lost.
    task automatic model_edge();
        bit pop_m;
        if (rstB) begin
            q.delete();
            m_ovf   = 0;
            m_drops = 0;
        end else begin
            pop_m = (q.size() > 0) && Ready_clkB;
            if (FlagIn_clkB && q.size() == 4 && !pop_m) begin
                m_ovf   = 1;
                m_drops = ClearOverflow ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
            end else if (ClearOverflow) begin
                m_ovf   = 0;
                m_drops = 0;
            end
            if (pop_m) void'(q.pop_front());
            if (FlagIn_clkB && (q.size() < 4)) q.push_back(BusIn);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(Count), 32'(q.size()));
        chk({tag, ".valid"}, 32'(Valid_clkB), 32'(q.size() != 0));
        chk({tag, ".data"}, 32'(DataOut), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".ovf"}, 32'(Overflow_clkB), 32'(m_ovf));
        chk({tag, ".drops"}, 32'(DropCount), 32'(m_drops));
    endtask

    // One clock: drive inputs, advance model at the edge, compare #1 later.
    task automatic tick(input bit flag, input logic [7:0] data, input bit rdy,
                        input bit clr, input bit rst, input string tag);
        FlagIn_clkB   = flag;
        BusIn         = data;
        Ready_clkB    = rdy;
        ClearOverflow = clr;
        rstB          = rst;
        @(posedge clkB);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset state.
        tick(0, 8'h00, 0, 0, 1, "reset");
        chk("reset.count_zero", 32'(Count), 32'd0);
        chk("reset.data_zero", 32'(DataOut), 32'd0);

        // Single word, then one-cycle pop.
        tick(1, 8'hA5, 0, 0, 0, "single_push");
        chk("single.data_a5", 32'(DataOut), 32'hA5);
        tick(0, 8'h00, 1, 0, 0, "single_pop");
        chk("single.empty", 32'(Valid_clkB), 32'd0);

        // Fill four, drain in order; pointers wrap.
        for (int i = 1; i <= 4; i++) tick(1, 8'(i), 0, 0, 0, "fill4");
        chk("fill4.full", 32'(Count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain4.order", 32'(DataOut), 32'(i));
            tick(0, 8'h00, 1, 0, 0, "drain4");
        end
        chk("drain4.empty", 32'(Count), 32'd0);

        // Overflow when full with no consumer.
        for (int i = 1; i <= 4; i++) tick(1, 8'(8'h10 + i), 0, 0, 0, "fill_ovf");
        tick(1, 8'h55, 0, 0, 0, "drop55");
        chk("drop55.drops", 32'(DropCount), 32'd1);
        chk("drop55.ovf", 32'(Overflow_clkB), 32'd1);

        // Push and pop together when full: accepted, no drop.
        tick(1, 8'h66, 1, 0, 0, "full_pushpop");
        chk("full_pushpop.count", 32'(Count), 32'd4);
        chk("full_pushpop.drops", 32'(DropCount), 32'd1);
        for (int i = 0; i < 5; i++) tick(0, 8'h00, 1, 0, 0, "drain_66");
        chk("drain_66.empty", 32'(Valid_clkB), 32'd0);

        // Saturation of the drop counter.
        for (int i = 1; i <= 4; i++) tick(1, 8'(8'h20 + i), 0, 0, 0, "fill_sat");
        for (int i = 0; i < 300; i++) tick(1, 8'($urandom), 0, 0, 0, "sat");
        chk("sat.drops255", 32'(DropCount), 32'd255);
        tick(1, 8'h77, 0, 1, 0, "clr_with_drop");
        chk("clr_with_drop.drops", 32'(DropCount), 32'd1);
        chk("clr_with_drop.ovf", 32'(Overflow_clkB), 32'd1);
        tick(0, 8'h00, 0, 1, 0, "clr_alone");
        chk("clr_alone.ovf", 32'(Overflow_clkB), 32'd0);
        chk("clr_alone.count_kept", 32'(Count), 32'd4);
        for (int i = 0; i < 4; i++) tick(0, 8'h00, 1, 0, 0, "drain_sat");

        // Reset mid-operation with a coincident pulse.
        for (int i = 1; i <= 3; i++) tick(1, 8'(8'h30 + i), 0, 0, 0, "pre_rst");
        tick(1, 8'h99, 1, 0, 1, "mid_rst");
        chk("mid_rst.count", 32'(Count), 32'd0);
        chk("mid_rst.valid", 32'(Valid_clkB), 32'd0);
        tick(1, 8'h42, 0, 0, 0, "post_rst_push");
        chk("post_rst.first", 32'(DataOut), 32'h42);
        tick(0, 8'h00, 1, 0, 0, "post_rst_pop");

        // Randomized traffic: bursty pulses, random consumer, rare clear/reset.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 99) < 45), 8'($urandom), ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 99) < 3), ($urandom_range(0, 999) < 4), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
